// File: rtl/phy_link_ctrl.sv
// phy_link_ctrl: PHY bring-up sequencer (PLL, TX, RX resets/enables), comma training,
// then word forwarding from a valid/ready source with SKP insertion when it is empty.
module phy_link_ctrl #(
    parameter int PLL_CYC     = 16,
    parameter int LOCK_CYC    = 64,
    parameter int TRAIN_WORDS = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        disable_i,
    input  logic [1:0]  pclk_cfg_i,
    input  logic [31:0] src_data_i,
    input  logic        src_k_i,
    input  logic        src_valid_i,
    output logic        src_ready_o,
    output logic [1:0]  pclk_o,
    output logic [31:0] in_data_o,
    output logic        k_o,
    output logic        reset_pll_o,
    output logic        reset_ps_o,
    output logic        reset_sp_o,
    output logic        reset_conv832_o,
    output logic        enb_conv_o,
    output logic        link_up_o
);
    localparam logic [31:0] COM = 32'hBCBCBCBC;
    localparam logic [31:0] SKP = 32'h1C1C1C1C;

    typedef enum logic [2:0] {IDLE, PLL_RST, PLL_WAIT, TX_EN, TRAIN, DATA} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  wcnt_q, wcnt_d;
    logic [1:0]  pclk_q, pclk_d;
    logic [31:0] data_q, data_d;
    logic        k_q, k_d;
    logic        pll_q, pll_d;
    logic        tx_q, tx_d;
    logic        rx_q, rx_d;
    logic        up_q, up_d;
    logic        wrap;

    // Last cycle of a word period: WORD_CYC = 8 << pclk
    assign wrap = wcnt_q == 5'((6'd8 << pclk_q) - 6'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        pclk_d  = pclk_q;
        data_d  = data_q;
        k_d     = k_q;
        pll_d   = pll_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        up_d    = up_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = PLL_RST;
                cnt_d   = '0;
                wcnt_d  = '0;
                pclk_d  = (pclk_cfg_i == 2'd3) ? 2'd2 : pclk_cfg_i;
            end
            PLL_RST: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(PLL_CYC - 1)) begin
                    state_d = PLL_WAIT;
                    cnt_d   = '0;
                    pll_d   = 1'b1;
                end
            end
            PLL_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(LOCK_CYC - 1)) begin
                    state_d = TX_EN;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            TX_EN: begin
                state_d = TRAIN;
                wcnt_d  = '0;
                cnt_d   = 8'd1;
                rx_d    = 1'b1;
                data_d  = COM;
                k_d     = 1'b1;
            end
            TRAIN: begin
                wcnt_d = wrap ? 5'd0 : wcnt_q + 5'd1;
                // cnt holds the number of COM words already loaded
                if (wrap && cnt_q == 8'(TRAIN_WORDS)) begin
                    state_d = DATA;
                    up_d    = 1'b1;
                    data_d  = SKP;
                    k_d     = 1'b1;
                end else if (wrap) begin
                    cnt_d  = cnt_q + 8'd1;
                    data_d = COM;
                    k_d    = 1'b1;
                end
            end
            DATA: begin
                wcnt_d = wrap ? 5'd0 : wcnt_q + 5'd1;
                if (wrap) begin
                    data_d = src_valid_i ? src_data_i : SKP;
                    k_d    = src_valid_i ? src_k_i : 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (disable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            wcnt_d  = '0;
            pclk_d  = '0;
            data_d  = '0;
            k_d     = 1'b0;
            pll_d   = 1'b0;
            tx_d    = 1'b0;
            rx_d    = 1'b0;
            up_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            pclk_q  <= '0;
            data_q  <= '0;
            k_q     <= 1'b0;
            pll_q   <= 1'b0;
            tx_q    <= 1'b0;
            rx_q    <= 1'b0;
            up_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            pclk_q  <= pclk_d;
            data_q  <= data_d;
            k_q     <= k_d;
            pll_q   <= pll_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            up_q    <= up_d;
        end
    end

    // Gated by reset/disable so an aborted cycle never completes a transfer
    assign src_ready_o     = state_q == DATA && wrap && !disable_i && !reset_i;
    assign pclk_o          = pclk_q;
    assign in_data_o       = data_q;
    assign k_o             = k_q;
    assign reset_pll_o     = pll_q;
    assign reset_ps_o      = tx_q;
    assign enb_conv_o      = tx_q;
    assign reset_sp_o      = rx_q;
    assign reset_conv832_o = up_q;
    assign link_up_o       = up_q;
endmodule

// File: tb/tb_phy_link_ctrl.sv
// tb_phy_link_ctrl: directed table-driven bring-up check plus hand-written
// streaming, SKP, abort and reset sequences for phy_link_ctrl.
module tb_phy_link_ctrl;
    localparam logic [31:0] COM = 32'hBCBCBCBC;
    localparam logic [31:0] SKP = 32'h1C1C1C1C;

    logic        clk = 1'b0;
    logic        reset, start, dis, src_k, src_valid;
    logic [1:0]  pclk_cfg;
    logic [31:0] src_data;
    logic        src_ready, k, rpll, rps, rsp, rconv, enb, link;
    logic [1:0]  pclk;
    logic [31:0] in_data;

    int n_cmp = 0;
    int n_err = 0;
    int n = 0;

    always #5 clk = ~clk;

    phy_link_ctrl #(.PLL_CYC(4), .LOCK_CYC(8), .TRAIN_WORDS(2)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .disable_i(dis),
        .pclk_cfg_i(pclk_cfg), .src_data_i(src_data), .src_k_i(src_k),
        .src_valid_i(src_valid), .src_ready_o(src_ready), .pclk_o(pclk),
        .in_data_o(in_data), .k_o(k), .reset_pll_o(rpll), .reset_ps_o(rps),
        .reset_sp_o(rsp), .reset_conv832_o(rconv), .enb_conv_o(enb),
        .link_up_o(link)
    );

    // {rpll, rps, enb, rsp, rconv, link, pclk, k, in_data}
    function automatic logic [40:0] obs();
        return {rpll, rps, enb, rsp, rconv, link, pclk, k, in_data};
    endfunction

    task automatic chk(input string name, input logic [40:0] act, input logic [40:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @n=%0d got=%h want=%h", name, n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic step_to(input int t);
        while (n < t) tick();
    endtask

    // Edge E: START sampled in IDLE; afterwards n counts edges since E
    task automatic do_start(input logic [1:0] cfg);
        pclk_cfg = cfg;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
    endtask

    task automatic wait_ready(input string name, input int want_gap);
        int gap = 0;
        while (!src_ready && gap < 64) begin
            tick();
            gap++;
        end
        chk({name, "_gap"}, 41'(gap), 41'(want_gap));
    endtask

    typedef struct {
        int          t;
        logic [40:0] exp;
        logic        dm;
        logic        rdy;
        logic [1:0]  cfg_after;
    } vec_t;

    vec_t vecs[15];

    initial begin
        reset = 1'b1; start = 1'b0; dis = 1'b0; pclk_cfg = 2'd0;
        src_data = '0; src_k = 1'b0; src_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_outs", obs(), '0);
        chk("reset_rdy", 41'(src_ready), 41'(0));

        vecs[0]  = '{0,   {6'b000000, 2'd2, 1'b0, 32'h0}, 1'b1, 1'b0, 2'd2};
        vecs[1]  = '{3,   {6'b000000, 2'd2, 1'b0, 32'h0}, 1'b1, 1'b0, 2'd2};
        vecs[2]  = '{4,   {6'b100000, 2'd2, 1'b0, 32'h0}, 1'b1, 1'b0, 2'd2};
        vecs[3]  = '{11,  {6'b100000, 2'd2, 1'b0, 32'h0}, 1'b1, 1'b0, 2'd2};
        vecs[4]  = '{12,  {6'b111000, 2'd2, 1'b0, 32'h0}, 1'b1, 1'b0, 2'd2};
        vecs[5]  = '{13,  {6'b111100, 2'd2, 1'b1, COM},   1'b1, 1'b0, 2'd2};
        vecs[6]  = '{20,  {6'b111100, 2'd2, 1'b1, COM},   1'b1, 1'b0, 2'd0};
        vecs[7]  = '{44,  {6'b111100, 2'd2, 1'b1, COM},   1'b1, 1'b0, 2'd0};
        vecs[8]  = '{45,  {6'b111100, 2'd2, 1'b1, COM},   1'b1, 1'b0, 2'd0};
        vecs[9]  = '{76,  {6'b111100, 2'd2, 1'b1, COM},   1'b1, 1'b0, 2'd0};
        vecs[10] = '{77,  {6'b111111, 2'd2, 1'b0, 32'h0}, 1'b0, 1'b0, 2'd0};
        vecs[11] = '{107, {6'b111111, 2'd2, 1'b0, 32'h0}, 1'b0, 1'b0, 2'd0};
        vecs[12] = '{108, {6'b111111, 2'd2, 1'b0, 32'h0}, 1'b0, 1'b1, 2'd0};
        vecs[13] = '{109, {6'b111111, 2'd2, 1'b1, SKP},   1'b1, 1'b0, 2'd0};
        vecs[14] = '{109, {6'b111111, 2'd2, 1'b1, SKP},   1'b1, 1'b0, 2'd0};

        do_start(2'd2);
        for (int i = 0; i < 15; i++) begin
            logic [40:0] m;
            step_to(vecs[i].t);
            m = vecs[i].dm ? {41{1'b1}} : {{8{1'b1}}, 33'h0};
            chk($sformatf("vec%0d", i), obs() & m, vecs[i].exp & m);
            chk($sformatf("vec%0d_rdy", i), 41'(src_ready), 41'(vecs[i].rdy));
            pclk_cfg = vecs[i].cfg_after;
        end

        // Streaming: one word per 32 cycles, K follows SRC_K, no SKP
        src_valid = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            src_data = 32'(w);
            src_k = w[0];
            wait_ready($sformatf("stream%0d", w), 31);
            tick();
            chk($sformatf("stream%0d_word", w), {8'h0, k, in_data}, {8'h0, w[0], 32'(w)});
            chk($sformatf("stream%0d_pulse", w), 41'(src_ready), 41'(0));
        end
        chk("stream_pclk_held", 41'(pclk), 41'(2));

        // DISABLE on a ready cycle: no transfer, everything clears
        src_data = 32'hCAFE0004;
        wait_ready("dis_ready", 31);
        dis = 1'b1;
        #1;
        chk("dis_rdy_drop", 41'(src_ready), 41'(0));
        tick();
        dis = 1'b0;
        chk("dis_outs", obs(), '0);
        src_valid = 1'b0;

        // DISABLE+START together in PLL_WAIT, then START held restarts bring-up
        do_start(2'd3);
        chk("cfg3_pclk", 41'(pclk), 41'(2));
        step_to(6);
        chk("pllwait_rpll", 41'(rpll), 41'(1));
        dis = 1'b1;
        start = 1'b1;
        tick();
        dis = 1'b0;
        chk("abort_outs", obs(), '0);
        tick();
        start = 1'b0;
        n = 0;
        chk("restart_n0", obs(), {6'b000000, 2'd2, 1'b0, 32'h0});
        step_to(3);
        chk("restart_rpll_lo", 41'(rpll), 41'(0));
        step_to(4);
        chk("restart_rpll_hi", 41'(rpll), 41'(1));

        // PCLK_CFG=0: SKP every 8 cycles, then RESET on a ready cycle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_start(2'd0);
        step_to(28);
        chk("w8_link_lo", 41'(link), 41'(0));
        step_to(29);
        chk("w8_link_hi", 41'(link), 41'(1));
        step_to(35);
        chk("w8_rdy35", 41'(src_ready), 41'(0));
        step_to(36);
        chk("w8_rdy36", 41'(src_ready), 41'(1));
        step_to(37);
        chk("w8_skp1", {8'h0, k, in_data}, {8'h0, 1'b1, SKP});
        chk("w8_rdy37", 41'(src_ready), 41'(0));
        step_to(43);
        chk("w8_rdy43", 41'(src_ready), 41'(0));
        step_to(44);
        chk("w8_rdy44", 41'(src_ready), 41'(1));
        src_valid = 1'b1;
        src_data = 32'hDEADBEEF;
        src_k = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_rdy_drop", 41'(src_ready), 41'(0));
        tick();
        reset = 1'b0;
        chk("rst_outs", obs(), '0);
        tick();
        chk("rst_idle", obs(), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
